// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares a single SDRAM controller command port among NUM_PORTS requesters.
// A two-state FSM (ARB / ISSUE) picks a winner, then holds its command on the
// controller until cmd_ready. Read responses come back in issue order and are
// steered to the issuing port through a small tag FIFO.
//
// Build option: define SDRAM_ARB_FIXED_PRIO_EN to replace round-robin with
// fixed priority (lowest eligible index wins). Ports and timing are identical
// in both builds.
//
// RD_DEPTH must be a power of two and at least 2.

module sdram_port_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int RD_DEPTH  = 4,
    parameter int ADDR_W    = 26
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req_valid,
    output logic [NUM_PORTS-1:0]          req_ready,
    input  logic [NUM_PORTS-1:0]          req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*16-1:0]       req_wdata,
    input  logic [NUM_PORTS*2-1:0]        req_wstrb,
    output logic [NUM_PORTS-1:0]          rsp_valid,
    output logic [15:0]                   rsp_data,
    output logic                          read,
    output logic                          write,
    output logic [ADDR_W-1:0]             addr,
    output logic [1:0]                    wr_strb,
    output logic [15:0]                   data_write,
    input  logic                          cmd_ready,
    input  logic [15:0]                   data_read,
    input  logic                          data_read_val,
    output logic [$clog2(RD_DEPTH):0]     rd_outstanding,
    output logic                          err_orphan
);

    localparam int PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TW     = $clog2(RD_DEPTH);
    localparam int CW     = TW + 1;
    localparam int DATA_W = 16;

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [PW-1:0]         r_grant;
    logic [PW-1:0]         r_last_grant;
    logic [PW-1:0]         w_winner;
    logic                  w_win_found;
    logic [NUM_PORTS-1:0]  w_eligible;

    logic [PW-1:0]         r_tag_mem [RD_DEPTH];
    logic [TW-1:0]         r_wr_ptr;
    logic [TW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_err_orphan;

    logic                  w_in_issue;
    logic                  w_g_write;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_tag_full;

    // Return-path control: a pop frees a slot in the same cycle, so a read
    // may win arbitration in the very cycle the FIFO drains one entry.
    assign w_pop      = data_read_val && (r_count != '0);
    assign w_tag_full = (r_count == CW'(RD_DEPTH)) && !w_pop;

    // Issue qualifiers; everything command-facing is forced low while reset is held.
    assign w_in_issue = (r_state == ST_ISSUE) && !reset;
    assign w_g_write  = req_write[r_grant];
    assign w_accept   = w_in_issue && cmd_ready;
    assign w_push     = w_accept && !w_g_write;

    // Eligibility: writes always qualify, reads only while a tag slot is free.
    always_comb begin
        w_eligible = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_eligible[p] = req_valid[p] && (req_write[p] || !w_tag_full);
        end
    end

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    // Fixed priority: scan from the top so the lowest eligible index is the last write.
    always_comb begin
        w_winner    = '0;
        w_win_found = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner    = PW'(i);
                w_win_found = 1'b1;
            end
        end
    end
`else
    // Round-robin: search last_grant+1 upward with wrap; scanning the offsets
    // in reverse leaves the nearest eligible port as the final assignment.
    always_comb begin
        logic [PW:0] idx;
        w_winner    = '0;
        w_win_found = 1'b0;
        idx         = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = {1'b0, r_last_grant} + (PW+1)'(i);
            if (idx >= (PW+1)'(NUM_PORTS)) begin
                idx = idx - (PW+1)'(NUM_PORTS);
            end
            if (w_eligible[idx[PW-1:0]]) begin
                w_winner    = idx[PW-1:0];
                w_win_found = 1'b1;
            end
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and controller-facing command outputs.
    always_comb begin
        w_state_nxt = r_state;
        read        = 1'b0;
        write       = 1'b0;
        addr        = '0;
        wr_strb     = '0;
        data_write  = '0;
        req_ready   = '0;
        case (r_state)
            ST_ARB: begin
                if (w_win_found) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_in_issue) begin
                    read       = !w_g_write;
                    write      = w_g_write;
                    addr       = req_addr[r_grant*ADDR_W +: ADDR_W];
                    wr_strb    = req_wstrb[r_grant*2 +: 2];
                    data_write = req_wdata[r_grant*DATA_W +: DATA_W];
                end
                if (w_accept) begin
                    req_ready   = NUM_PORTS'(1) << r_grant;
                    w_state_nxt = ST_ARB;
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase
    end

    // Grant bookkeeping: capture the winner in ARB, remember it once accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant      <= '0;
            r_last_grant <= PW'(NUM_PORTS - 1);
        end else begin
            if ((r_state == ST_ARB) && w_win_found) begin
                r_grant <= w_winner;
            end
            if (w_accept) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Tag FIFO storage holds the issuing port of each outstanding read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= r_grant;
        end
    end

    // Tag FIFO pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag for read data arriving with no read outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_orphan <= 1'b0;
        end else if (data_read_val && (r_count == '0)) begin
            r_err_orphan <= 1'b1;
        end
    end

    // Response steering: the head tag selects which port sees this beat.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (w_pop && !reset) begin
            rsp_valid = NUM_PORTS'(1) << r_tag_mem[r_rd_ptr];
            rsp_data  = data_read;
        end
    end

    assign rd_outstanding = reset ? '0 : r_count;
    assign err_orphan     = r_err_orphan && !reset;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter
// Directed vectors with hand-computed expectations for sdram_port_arbiter.
// Honours SDRAM_ARB_FIXED_PRIO_EN for the grant-order expectations.

module tb_sdram_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 26;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP-1:0]   req_valid;
    logic [NP-1:0]   req_ready;
    logic [NP-1:0]   req_write;
    logic [NP*AW-1:0] req_addr;
    logic [NP*16-1:0] req_wdata;
    logic [NP*2-1:0] req_wstrb;
    logic [NP-1:0]   rsp_valid;
    logic [15:0]     rsp_data;
    logic            read;
    logic            write;
    logic [AW-1:0]   addr;
    logic [1:0]      wr_strb;
    logic [15:0]     data_write;
    logic            cmd_ready;
    logic [15:0]     data_read;
    logic            data_read_val;
    logic [2:0]      rd_outstanding;
    logic            err_orphan;

    int n_total = 0;
    int n_bad   = 0;

    sdram_port_arbiter #(.NUM_PORTS(NP), .RD_DEPTH(4), .ADDR_W(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wstrb     (req_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .read          (read),
        .write         (write),
        .addr          (addr),
        .wr_strb       (wr_strb),
        .data_write    (data_write),
        .cmd_ready     (cmd_ready),
        .data_read     (data_read),
        .data_read_val (data_read_val),
        .rd_outstanding(rd_outstanding),
        .err_orphan    (err_orphan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_port(input logic [1:0] p, input logic wr, input logic [AW-1:0] a,
                            input logic [15:0] d, input logic [1:0] s);
        req_write[p]          = wr;
        req_addr[p*AW +: AW]  = a;
        req_wdata[p*16 +: 16] = d;
        req_wstrb[p*2 +: 2]   = s;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        req_valid     = '0;
        cmd_ready     = 1'b0;
        data_read_val = 1'b0;
        data_read     = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Present one command on port p and wait (bounded) for its acceptance.
    task automatic issue(input logic [1:0] p, input logic wr, input logic [AW-1:0] a);
        logic got;
        got = 1'b0;
        set_port(p, wr, a, 16'h0, 2'b00);
        req_valid[p] = 1'b1;
        cmd_ready    = 1'b1;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            settle();
            if (req_ready[p]) got = 1'b1;
        end
        chk("issue_ack", 32'(got), 32'd1);
        tick();
        req_valid[p] = 1'b0;
        cmd_ready    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_port [5];
        logic [1:0] strb_tab [4];
        logic [3:0] rsp_tab  [3];

`ifdef SDRAM_ARB_FIXED_PRIO_EN
        exp_port = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
        exp_port = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
        strb_tab = '{2'b01, 2'b10, 2'b11, 2'b01};
        rsp_tab  = '{4'b0001, 4'b1000, 4'b0010};

        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;

        // ---------------- reset state ----------------
        reset         = 1'b1;
        req_valid     = '0;
        cmd_ready     = 1'b0;
        data_read_val = 1'b0;
        data_read     = '0;
        tick();
        settle();
        chk("rst_read",   32'(read), 32'd0);
        chk("rst_write",  32'(write), 32'd0);
        chk("rst_ready",  32'(req_ready), 32'd0);
        chk("rst_rdout",  32'(rd_outstanding), 32'd0);
        chk("rst_orphan", 32'(err_orphan), 32'd0);
        do_reset();

        // ---------------- test 1: single read, port 2 ----------------
        set_port(2'd2, 1'b0, 26'h0012345, 16'h0, 2'b00);
        req_valid[2] = 1'b1;
        cmd_ready    = 1'b0;
        tick();
        for (int c = 0; c < 3; c++) begin
            if (c == 2) cmd_ready = 1'b1;
            settle();
            chk("t1_read",  32'(read), 32'd1);
            chk("t1_addr",  32'(addr), 32'h0012345);
            chk("t1_ready", 32'(req_ready), (c == 2) ? 32'h4 : 32'h0);
            tick();
        end
        req_valid[2] = 1'b0;
        cmd_ready    = 1'b0;
        settle();
        chk("t1_idle_read", 32'(read), 32'd0);
        chk("t1_idle_addr", 32'(addr), 32'd0);
        chk("t1_rdout1",    32'(rd_outstanding), 32'd1);
        for (int c = 0; c < 4; c++) tick();
        chk("t1_norsp", 32'(rsp_valid), 32'd0);
        data_read_val = 1'b1;
        data_read     = 16'hBEEF;
        settle();
        chk("t1_rsp_valid", 32'(rsp_valid), 32'b0100);
        chk("t1_rsp_data",  32'(rsp_data), 32'hBEEF);
        tick();
        data_read_val = 1'b0;
        settle();
        chk("t1_rsp_done", 32'(rsp_valid), 32'd0);
        chk("t1_rdout0",   32'(rd_outstanding), 32'd0);

        // ---------------- test 2: four writers, grant order ----------------
        do_reset();
        for (int p = 0; p < NP; p++) begin
            set_port(2'(p), 1'b1, 26'(32'h100 + p), 16'(32'hA000 + p), strb_tab[p]);
        end
        req_valid = 4'b1111;
        cmd_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            settle();
            chk("t2_write", 32'(write), 32'd1);
            chk("t2_read",  32'(read), 32'd0);
            chk("t2_grant", 32'(req_ready), 32'(4'b0001 << exp_port[k]));
            chk("t2_data",  32'(data_write), 32'hA000 + 32'(exp_port[k]));
            chk("t2_strb",  32'(wr_strb), 32'(strb_tab[exp_port[k]]));
            chk("t2_addr",  32'(addr), 32'h100 + 32'(exp_port[k]));
            tick();
            settle();
            chk("t2_bubble", 32'(write), 32'd0);
        end
        req_valid = '0;
        cmd_ready = 1'b0;

        // ---------------- test 3: tag FIFO full stalls reads ----------------
        do_reset();
        set_port(2'd1, 1'b0, 26'h0000201, 16'h0, 2'b00);
        set_port(2'd3, 1'b1, 26'h0000303, 16'h3333, 2'b11);
        req_valid[1] = 1'b1;
        cmd_ready    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            settle();
            chk("t3_rd_issue", 32'(read), 32'd1);
            tick();
            settle();
            chk("t3_rdout", 32'(rd_outstanding), 32'(i + 1));
        end
        req_valid[3] = 1'b1;
        cmd_ready    = 1'b0;
        tick();
        settle();
        chk("t3_wr_grant", 32'(write), 32'd1);
        chk("t3_wr_addr",  32'(addr), 32'h0000303);
        tick();
        settle();
        chk("t3_wr_hold", 32'(write), 32'd1);
        chk("t3_no_read", 32'(read), 32'd0);
        cmd_ready = 1'b1;
        settle();
        chk("t3_wr_ready", 32'(req_ready), 32'b1000);
        tick();
        req_valid[3] = 1'b0;
        settle();
        chk("t3_arb_idle", 32'(read | write), 32'd0);
        tick();
        settle();
        chk("t3_stalled", 32'(read), 32'd0);
        chk("t3_full",    32'(rd_outstanding), 32'd4);
        data_read_val = 1'b1;
        data_read     = 16'h1111;
        settle();
        chk("t3_pop_rsp", 32'(rsp_valid), 32'b0010);
        tick();
        data_read_val = 1'b0;
        settle();
        chk("t3_rd5_issue", 32'(read), 32'd1);
        chk("t3_rdout3",    32'(rd_outstanding), 32'd3);
        chk("t3_rd5_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid[1] = 1'b0;
        cmd_ready    = 1'b0;
        settle();
        chk("t3_rdout4", 32'(rd_outstanding), 32'd4);

        // ---------------- test 4: interleaved read return ----------------
        do_reset();
        issue(2'd0, 1'b0, 26'h0000010);
        issue(2'd3, 1'b0, 26'h0000013);
        issue(2'd1, 1'b0, 26'h0000011);
        settle();
        chk("t4_rdout3", 32'(rd_outstanding), 32'd3);
        for (int k = 0; k < 3; k++) begin
            data_read_val = 1'b1;
            data_read     = 16'(32'hD000 + k);
            settle();
            chk("t4_rsp_valid", 32'(rsp_valid), 32'(rsp_tab[k]));
            chk("t4_rsp_data",  32'(rsp_data), 32'hD000 + 32'(k));
            tick();
            data_read_val = 1'b0;
            tick();
        end
        settle();
        chk("t4_rdout0", 32'(rd_outstanding), 32'd0);

        // ---------------- test 5: orphan data ----------------
        data_read_val = 1'b1;
        data_read     = 16'h5A5A;
        settle();
        chk("t5_no_rsp",   32'(rsp_valid), 32'd0);
        chk("t5_pre_flag", 32'(err_orphan), 32'd0);
        tick();
        data_read_val = 1'b0;
        settle();
        chk("t5_flag_set", 32'(err_orphan), 32'd1);
        for (int c = 0; c < 3; c++) tick();
        chk("t5_flag_sticky", 32'(err_orphan), 32'd1);
        chk("t5_rdout",       32'(rd_outstanding), 32'd0);
        do_reset();
        settle();
        chk("t5_flag_clr", 32'(err_orphan), 32'd0);

        // ---------------- test 6: reset while in ISSUE ----------------
        issue(2'd0, 1'b0, 26'h0000020);
        settle();
        chk("t6_rdout1", 32'(rd_outstanding), 32'd1);
        set_port(2'd2, 1'b1, 26'h0000222, 16'h2222, 2'b10);
        req_valid[2] = 1'b1;
        cmd_ready    = 1'b0;
        tick();
        settle();
        chk("t6_issue_wr",   32'(write), 32'd1);
        chk("t6_issue_data", 32'(data_write), 32'h2222);
        reset = 1'b1;
        settle();
        chk("t6_rst_during", 32'(write), 32'd0);
        tick();
        settle();
        chk("t6_rst_read",  32'(read), 32'd0);
        chk("t6_rst_write", 32'(write), 32'd0);
        chk("t6_rst_rdout", 32'(rd_outstanding), 32'd0);
        reset        = 1'b0;
        req_valid[2] = 1'b0;
        tick();
        settle();
        chk("t6_post_write", 32'(write), 32'd0);
        chk("t6_post_ready", 32'(req_ready), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
